trap_csr_ctrl: RTL and testbench
================================

// Module: trap_csr_ctrl
// PURPOSE
// - Machine-mode CSR file and trap sequencer, directly downstream of the exception/interrupt detector.
// - Takes one pre-prioritised synchronous exception per cycle, plus external/software interrupt lines and MRET.
// - Updates mepc/mcause/mtval/mstatus, then issues a one-cycle pipeline flush and PC redirect into mtvec (or back to mepc).
// - Also serves CSR read/write/set/clear for Zicsr instructions in EXE.
// PARAMETERS
// - RESET_MTVEC   32'h0000_0100   mtvec value after reset
// - XLEN          32              data width; only 32 is supported
// PORTS
// - clk           in   1   system clock
// - rstn          in   1   asynchronous active-low reset
// - exc_valid     in   1   synchronous exception request from the detector
// - exc_cause     in   4   exception code (0 instr misaligned, 1 instr fault, 4/5 load, 6/7 store)
// - exc_pc        in   32  PC of the faulting instruction
// - exc_tval      in   32  faulting address
// - int_pc        in   32  PC of the oldest unretired instruction; saved as mepc on an interrupt
// - irq_meip      in   1   external interrupt, level
// - irq_msip      in   1   software interrupt, level
// - mret          in   1   MRET in EXE
// - csr_op        in   2   00 none, 01 write, 10 set, 11 clear
// - csr_addr      in   12  CSR address
// - csr_wdata     in   32  rs1 or immediate operand
// - csr_rdata     out  32  old CSR value; combinational
// - csr_illegal   out  1   csr_op!=0 and the address is unimplemented
// - redirect      out  1   one-cycle PC redirect strobe
// - redirect_pc   out  32  target PC, valid while redirect=1
// - flush         out  1   flushes IF/ID/EXE; equals redirect
// BEHAVIOUR
// - CSRs and their fields:
//   - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11] read 2'b11; all other bits read 0.
//   - mie 0x304: bits 11/7/3 writable only. mtvec 0x305: MODE[1:0], where 0 is direct and 1 is vectored.
//   - mscratch 0x340. mepc 0x341: bits[1:0] always 0. mcause 0x342. mtval 0x343.
//   - mip 0x344: read-only {MEIP[11], MTIP[7], MSIP[3]}.
// - Reset values: all CSRs 0, except mtvec=RESET_MTVEC. Outputs: redirect=0, flush=0, redirect_pc=0. State=IDLE.
// - FSM states: IDLE, TRAP, RET.
//   - Every decision is made only in IDLE. Priority: exc_valid > interrupt > mret.
//   - An interrupt is pending when mstatus.MIE=1 and (mip & mie) != 0. Order among interrupts: MEI(11) > MSI(3) > MTI(7).
//   - IDLE->TRAP on a taken trap at edge N. On that edge:
//     - mepc <= exc_pc or int_pc; mcause <= {isInt, 27'b0, code}.
//     - mtval <= exc_tval for an exception, 0 for an interrupt.
//     - MPIE <= MIE; MIE <= 0.
//   - IDLE->RET on mret at edge N. On that edge: MIE <= MPIE; MPIE <= 1.
//   - TRAP->IDLE and RET->IDLE unconditionally at edge N+1.
// - Redirect timing:
//   - redirect and flush are registered, high for exactly the cycle after edge N.
//   - TRAP target: mtvec & ~3. If MODE=1 and the trap is an interrupt, target is (mtvec & ~3) + 4*code.
//   - RET target: mepc.
// - Inputs exc_valid, mret and csr_op are ignored in TRAP and RET; the pipeline is being flushed.
// - CSR write when csr_op!=0 in IDLE and no trap/mret is taken that cycle:
//   - new = wdata, old|wdata or old&~wdata for ops 01, 10, 11.
//   - A simultaneous trap or mret wins; the CSR write is discarded.
//   - Writes to mip or unimplemented addresses have no effect.
// - mip.MEIP and mip.MSIP follow the input pins one cycle late; they are synchronised by a single flop.
// - When rstn is asserted mid-TRAP or mid-RET, the sequence aborts immediately: no redirect, and CSRs take reset values.
// CONFIGURATION
// - TRAP_MTIMER_EN defined:
//   - Adds a 64-bit mtime that increments every cycle and a 64-bit mtimecmp, reset to all-ones.
//   - CSR addresses: mtime lo/hi at 0x7C0/0x7C1, mtimecmp lo/hi at 0x7C2/0x7C3.
//   - MTIP = (mtime >= mtimecmp), registered. mtime wraps 2^64-1 -> 0.
// - TRAP_MTIMER_EN undefined: MTIP=0; addresses 0x7C0-0x7C3 are unimplemented and assert csr_illegal.
// TESTING
// - Store exception: exc_valid=1, cause=6, pc=0x40, tval=0x103, MIE=1, mtvec=0x100.
//   -> next cycle redirect=1, redirect_pc=0x100; mepc=0x40, mcause=6, mtval=0x103, MIE=0, MPIE=1.
// - Vectored external interrupt: mtvec=0x201, mie=0x800, MIE=1, irq_meip=1, int_pc=0x88.
//   -> redirect_pc=0x22C, mcause=0x8000000B, mepc=0x88.
// - MRET: mepc=0x44, MPIE=1, mret=1 -> next cycle redirect=1, redirect_pc=0x44, MIE=1.
// - Collision: exc_valid and csr_op=01 to mscratch (0xDEAD) in the same cycle -> trap taken, mscratch unchanged.
// - Set/clear: csrrs mstatus 0x8, then csrrc 0x8 -> csr_rdata reads 0x1800, 0x1808; final MIE=0.
// - Timer (TRAP_MTIMER_EN): mtimecmp=20, mie=0x80, MIE=1.
//   -> MTIP rises; mcause=0x80000007 once mtime>=20.
//   -> With MIE=1, irq_meip=1 and MTIP=1 in the same cycle, mcause=0x8000000B (MEI wins).

Source files
------------

// File: rtl/trap_csr_ctrl.sv
// Machine-mode CSR file and trap/MRET sequencer with one-cycle flush and PC redirect.
// Optional feature macro: TRAP_MTIMER_EN adds a 64-bit mtime/mtimecmp timer driving MTIP.
module trap_csr_ctrl #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter int          XLEN        = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0] int_pc,
  input  logic            irq_meip,
  input  logic            irq_msip,
  input  logic            mret,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush
);

  typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;

  state_t      state_q, state_d;
  logic        mie_bit, mpie_bit;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic        meip_p1, msip_p1, mtip;
  logic [31:0] mip_val, trap_base, trap_target, redirect_pc_p1, csr_new;
  logic        int_pend, take_exc, take_int, take_ret, csr_we, csr_hit;
  logic [3:0]  int_code;
  logic        timer_hit;
  logic [31:0] timer_rdata;

  assign mip_val  = {20'b0, meip_p1, 3'b0, mtip, 3'b0, msip_p1, 3'b0};
  assign int_pend = mie_bit && ((mip_val & mie_q) != 32'b0);

  // Interrupt priority MEI > MSI > MTI
  always_comb begin
    if (meip_p1 && mie_q[11])     int_code = 4'd11;
    else if (msip_p1 && mie_q[3]) int_code = 4'd3;
    else                          int_code = 4'd7;
  end

  assign trap_base   = {mtvec_q[31:2], 2'b00};
  assign trap_target = (take_int && mtvec_q[1:0] == 2'b01) ?
                       trap_base + {26'b0, int_code, 2'b00} : trap_base;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = IDLE;
    take_exc = 1'b0;
    take_int = 1'b0;
    take_ret = 1'b0;
    if (state_q == IDLE) begin
      if (exc_valid) begin
        take_exc = 1'b1;
        state_d  = TRAP;
      end else if (int_pend) begin
        take_int = 1'b1;
        state_d  = TRAP;
      end else if (mret) begin
        take_ret = 1'b1;
        state_d  = RET;
      end
    end
  end

  assign redirect    = (state_q != IDLE);
  assign flush       = redirect;
  assign redirect_pc = redirect_pc_p1;

  always_comb begin
    csr_hit   = 1'b1;
    csr_rdata = '0;
    case (csr_addr)
      12'h300: csr_rdata = {19'b0, 2'b11, 3'b0, mpie_bit, 3'b0, mie_bit, 3'b0};
      12'h304: csr_rdata = mie_q;
      12'h305: csr_rdata = mtvec_q;
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h343: csr_rdata = mtval_q;
      12'h344: csr_rdata = mip_val;
      default: begin
        csr_hit   = timer_hit;
        csr_rdata = timer_rdata;
      end
    endcase
  end

  always_comb begin
    case (csr_op)
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_rdata | csr_wdata;
      2'b11:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
  end

  assign csr_illegal = (csr_op != 2'b00) && !csr_hit;
  // A trap or MRET taken this cycle squashes the CSR instruction
  assign csr_we = (state_q == IDLE) && (csr_op != 2'b00) && csr_hit &&
                  !(take_exc || take_int || take_ret);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mie_bit        <= 1'b0;
      mpie_bit       <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      meip_p1        <= 1'b0;
      msip_p1        <= 1'b0;
      redirect_pc_p1 <= '0;
    end else begin
      meip_p1 <= irq_meip;
      msip_p1 <= irq_msip;
      if (take_exc || take_int) begin
        mepc_q         <= take_exc ? {exc_pc[31:2], 2'b00} : {int_pc[31:2], 2'b00};
        mcause_q       <= take_exc ? {28'b0, exc_cause} : {1'b1, 27'b0, int_code};
        mtval_q        <= take_exc ? exc_tval : '0;
        mpie_bit       <= mie_bit;
        mie_bit        <= 1'b0;
        redirect_pc_p1 <= trap_target;
      end else if (take_ret) begin
        mie_bit        <= mpie_bit;
        mpie_bit       <= 1'b1;
        redirect_pc_p1 <= mepc_q;
      end else if (csr_we) begin
        case (csr_addr)
          12'h300: begin
            mie_bit  <= csr_new[3];
            mpie_bit <= csr_new[7];
          end
          12'h304: mie_q      <= csr_new & 32'h0000_0888;
          12'h305: mtvec_q    <= csr_new;
          12'h340: mscratch_q <= csr_new;
          12'h341: mepc_q     <= {csr_new[31:2], 2'b00};
          12'h342: mcause_q   <= csr_new;
          12'h343: mtval_q    <= csr_new;
          default: ;
        endcase
      end
    end
  end

`ifdef TRAP_MTIMER_EN
  logic [63:0] mtime_q, mtimecmp_q;
  logic        mtip_p1;

  always_comb begin
    timer_hit   = 1'b1;
    timer_rdata = '0;
    case (csr_addr)
      12'h7C0: timer_rdata = mtime_q[31:0];
      12'h7C1: timer_rdata = mtime_q[63:32];
      12'h7C2: timer_rdata = mtimecmp_q[31:0];
      12'h7C3: timer_rdata = mtimecmp_q[63:32];
      default: timer_hit = 1'b0;
    endcase
  end

  // A software write to mtime replaces that cycle's increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      mtip_p1    <= 1'b0;
    end else begin
      mtip_p1 <= (mtime_q >= mtimecmp_q);
      if (csr_we && csr_addr == 12'h7C0)      mtime_q <= {mtime_q[63:32], csr_new};
      else if (csr_we && csr_addr == 12'h7C1) mtime_q <= {csr_new, mtime_q[31:0]};
      else                                    mtime_q <= mtime_q + 64'd1;
      if (csr_we && csr_addr == 12'h7C2) mtimecmp_q[31:0]  <= csr_new;
      if (csr_we && csr_addr == 12'h7C3) mtimecmp_q[63:32] <= csr_new;
    end
  end

  assign mtip = mtip_p1;
`else
  assign timer_hit   = 1'b0;
  assign timer_rdata = '0;
  assign mtip        = 1'b0;
`endif

endmodule

// File: tb/tb_trap_csr_ctrl.sv
// Bench for trap_csr_ctrl: architectural CSR model compared every cycle plus directed literal checks.
module tb_trap_csr_ctrl;
  logic        clk, rstn, exc_valid, irq_meip, irq_msip, mret;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, int_pc, csr_wdata, csr_rdata, redirect_pc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic        csr_illegal, redirect, flush;

  int checks = 0;
  int errors = 0;

  trap_csr_ctrl dut (
    .clk(clk), .rstn(rstn), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .int_pc(int_pc),
    .irq_meip(irq_meip), .irq_msip(irq_msip), .mret(mret),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model
  logic        m_mie_b, m_mpie, m_meip, m_msip, m_mtip, m_busy, exp_red;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, exp_rpc;
  logic [63:0] m_mtime, m_mtimecmp;
  logic [31:0] oldv, newv;
  logic        t_mtip, mtime_wr;
  int          code;

  function automatic logic m_hit(input logic [11:0] a);
    m_hit = (a == 12'h300) || (a == 12'h304) || (a == 12'h305) || (a == 12'h340) ||
            (a == 12'h341) || (a == 12'h342) || (a == 12'h343) || (a == 12'h344);
`ifdef TRAP_MTIMER_EN
    if (a >= 12'h7C0 && a <= 12'h7C3) m_hit = 1'b1;
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    m_read = 32'h0;
    case (a)
      12'h300: m_read = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie_b ? 32'h8 : 32'h0);
      12'h304: m_read = m_mie;
      12'h305: m_read = m_mtvec;
      12'h340: m_read = m_mscratch;
      12'h341: m_read = m_mepc;
      12'h342: m_read = m_mcause;
      12'h343: m_read = m_mtval;
      12'h344: m_read = (m_meip ? 32'h800 : 32'h0) + (m_mtip ? 32'h80 : 32'h0) +
                        (m_msip ? 32'h8 : 32'h0);
`ifdef TRAP_MTIMER_EN
      12'h7C0: m_read = m_mtime[31:0];
      12'h7C1: m_read = m_mtime[63:32];
      12'h7C2: m_read = m_mtimecmp[31:0];
      12'h7C3: m_read = m_mtimecmp[63:32];
`endif
      default: m_read = 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mie_b = 0; m_mpie = 0; m_meip = 0; m_msip = 0; m_mtip = 0; m_busy = 0;
      exp_red = 0; exp_rpc = 0; m_mie = 0; m_mtvec = 32'h100; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mtime = 0; m_mtimecmp = '1;
    end else begin
      t_mtip   = (m_mtime >= m_mtimecmp);
      mtime_wr = 0;
      exp_red  = 0;
      if (!m_busy) begin
        code = -1;
        if (m_mie_b) begin
          if (m_meip && m_mie[11])     code = 11;
          else if (m_msip && m_mie[3]) code = 3;
          else if (m_mtip && m_mie[7]) code = 7;
        end
        if (exc_valid) begin
          exp_rpc = m_mtvec & ~32'h3;
          m_mepc = exc_pc & ~32'h3; m_mcause = 32'(exc_cause); m_mtval = exc_tval;
          m_mpie = m_mie_b; m_mie_b = 0; exp_red = 1;
        end else if (code >= 0) begin
          exp_rpc = (m_mtvec & ~32'h3) + ((m_mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'h0);
          m_mepc = int_pc & ~32'h3; m_mcause = 32'h8000_0000 + 32'(code); m_mtval = 0;
          m_mpie = m_mie_b; m_mie_b = 0; exp_red = 1;
        end else if (mret) begin
          exp_rpc = m_mepc; m_mie_b = m_mpie; m_mpie = 1; exp_red = 1;
        end else if (csr_op != 2'b00 && m_hit(csr_addr)) begin
          oldv = m_read(csr_addr);
          newv = (csr_op == 2'b01) ? csr_wdata :
                 (csr_op == 2'b10) ? (oldv | csr_wdata) : (oldv & ~csr_wdata);
          case (csr_addr)
            12'h300: begin m_mie_b = newv[3]; m_mpie = newv[7]; end
            12'h304: m_mie = newv & 32'h888;
            12'h305: m_mtvec = newv;
            12'h340: m_mscratch = newv;
            12'h341: m_mepc = newv & ~32'h3;
            12'h342: m_mcause = newv;
            12'h343: m_mtval = newv;
`ifdef TRAP_MTIMER_EN
            12'h7C0: begin m_mtime[31:0] = newv; mtime_wr = 1; end
            12'h7C1: begin m_mtime[63:32] = newv; mtime_wr = 1; end
            12'h7C2: m_mtimecmp[31:0] = newv;
            12'h7C3: m_mtimecmp[63:32] = newv;
`endif
            default: ;
          endcase
        end
      end
      m_busy = exp_red;
`ifdef TRAP_MTIMER_EN
      if (!mtime_wr) m_mtime = m_mtime + 64'd1;
      m_mtip = t_mtip;
`endif
      m_meip = irq_meip;
      m_msip = irq_msip;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (redirect !== exp_red) begin
      errors++; $display("FAIL cyc_redirect actual=%b required=%b", redirect, exp_red);
    end
    checks++;
    if (flush !== exp_red) begin
      errors++; $display("FAIL cyc_flush actual=%b required=%b", flush, exp_red);
    end
    if (exp_red) begin
      checks++;
      if (redirect_pc !== exp_rpc) begin
        errors++; $display("FAIL cyc_redirect_pc actual=%h required=%h", redirect_pc, exp_rpc);
      end
    end
    checks++;
    if (csr_rdata !== m_read(csr_addr)) begin
      errors++; $display("FAIL cyc_rdata addr=%h actual=%h required=%h", csr_addr, csr_rdata, m_read(csr_addr));
    end
    checks++;
    if (csr_illegal !== (csr_op != 2'b00 && !m_hit(csr_addr))) begin
      errors++; $display("FAIL cyc_illegal addr=%h actual=%b", csr_addr, csr_illegal);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_op = 2'b00; csr_addr = a; #1;
    chk(name, csr_rdata, exp);
  endtask

  task automatic csrw(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op = op; csr_addr = a; csr_wdata = d;
    step();
    csr_op = 2'b00;
  endtask

  logic found;

  initial begin
    rstn = 0; exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; int_pc = 0;
    irq_meip = 0; irq_msip = 0; mret = 0; csr_op = 0; csr_addr = 12'h300; csr_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_redirect", {31'b0, redirect}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    peek("rst_mtvec", 12'h305, 32'h100);
    peek("rst_mstatus", 12'h300, 32'h1800);
    rstn = 1;
    step();

    // Set then clear mstatus.MIE
    csr_op = 2'b10; csr_addr = 12'h300; csr_wdata = 32'h8; #1;
    chk("csrrs_old", csr_rdata, 32'h1800);
    step();
    csr_op = 2'b11; #1;
    chk("csrrc_old", csr_rdata, 32'h1808);
    step();
    peek("csrrc_final", 12'h300, 32'h1800);

    // Illegal / read-only addresses
    csr_op = 2'b01; csr_addr = 12'h123; csr_wdata = 32'hFFFF; #1;
    chk("illegal_123", {31'b0, csr_illegal}, 32'h1);
`ifndef TRAP_MTIMER_EN
    csr_addr = 12'h7C0; #1;
    chk("illegal_7c0", {31'b0, csr_illegal}, 32'h1);
`endif
    step();
    csrw(2'b01, 12'h344, 32'hFFFF_FFFF);
    peek("mip_ro", 12'h344, 32'h0);

    // Store exception
    csrw(2'b01, 12'h300, 32'h8);
    exc_valid = 1; exc_cause = 4'd6; exc_pc = 32'h40; exc_tval = 32'h103;
    step();
    exc_valid = 0;
    chk("st_redirect", {31'b0, redirect}, 32'h1);
    chk("st_redirect_pc", redirect_pc, 32'h100);
    peek("st_mepc", 12'h341, 32'h40);
    peek("st_mcause", 12'h342, 32'h6);
    peek("st_mtval", 12'h343, 32'h103);
    peek("st_mstatus", 12'h300, 32'h1880);
    step();

    // Vectored external interrupt
    csrw(2'b01, 12'h305, 32'h201);
    csrw(2'b01, 12'h304, 32'h800);
    csrw(2'b01, 12'h300, 32'h8);
    int_pc = 32'h88; irq_meip = 1;
    step();
    chk("mei_sync_delay", {31'b0, redirect}, 32'h0);
    step();
    chk("mei_redirect", {31'b0, redirect}, 32'h1);
    chk("mei_redirect_pc", redirect_pc, 32'h22C);
    peek("mei_mcause", 12'h342, 32'h8000_000B);
    peek("mei_mepc", 12'h341, 32'h88);
    peek("mei_mtval", 12'h343, 32'h0);
    irq_meip = 0;
    step(); step();

    // MRET
    csrw(2'b01, 12'h341, 32'h44);
    mret = 1;
    step();
    mret = 0;
    chk("mret_redirect", {31'b0, redirect}, 32'h1);
    chk("mret_redirect_pc", redirect_pc, 32'h44);
    peek("mret_mstatus", 12'h300, 32'h1888);
    step();
    csrw(2'b01, 12'h304, 32'h0);

    // Trap vs. CSR write collision; write held into TRAP cycle is ignored too
    exc_valid = 1; exc_cause = 4'd4; exc_pc = 32'h60; exc_tval = 32'h7;
    csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hDEAD;
    step();
    exc_valid = 0;
    chk("col_redirect_pc", redirect_pc, 32'h200);
    step();
    csr_op = 2'b00;
    peek("col_mscratch", 12'h340, 32'h0);
    peek("col_mcause", 12'h342, 32'h4);

`ifdef TRAP_MTIMER_EN
    csrw(2'b01, 12'h7C0, 32'h0);
    csrw(2'b01, 12'h7C1, 32'h0);
    csrw(2'b01, 12'h7C2, 32'd20);
    csrw(2'b01, 12'h7C3, 32'h0);
    peek("tmr_mip_low", 12'h344, 32'h0);
    csrw(2'b01, 12'h304, 32'h80);
    csrw(2'b01, 12'h300, 32'h8);
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (redirect) found = 1;
    end
    chk("tmr_trap_seen", {31'b0, found}, 32'h1);
    chk("tmr_redirect_pc", redirect_pc, 32'h21C);
    peek("tmr_mcause", 12'h342, 32'h8000_0007);
    step();
    csrw(2'b01, 12'h304, 32'h880);
    irq_meip = 1;
    step(); step();
    csrw(2'b01, 12'h300, 32'h8);
    step();
    chk("mei_over_mti_redirect", {31'b0, redirect}, 32'h1);
    peek("mei_over_mti_mcause", 12'h342, 32'h8000_000B);
    irq_meip = 0;
    step();
    csrw(2'b01, 12'h304, 32'h0);
`endif

    // Reset asserted during TRAP aborts the redirect
    exc_valid = 1; exc_cause = 4'd1; exc_pc = 32'h500; exc_tval = 32'h500;
    step();
    exc_valid = 0;
    chk("abort_pre_redirect", {31'b0, redirect}, 32'h1);
    rstn = 0; #1;
    chk("abort_redirect", {31'b0, redirect}, 32'h0);
    chk("abort_flush", {31'b0, flush}, 32'h0);
    chk("abort_redirect_pc", redirect_pc, 32'h0);
    peek("abort_mepc", 12'h341, 32'h0);
    peek("abort_mtvec", 12'h305, 32'h100);
    step();
    rstn = 1;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
